// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit opcodes and the opcode legality check.
package alu_pkg;

  typedef enum logic [3:0] {
    LOP_AND    = 4'd0,
    LOP_OR     = 4'd1,
    LOP_XOR    = 4'd2,
    LOP_NOT    = 4'd3,
    LOP_TEST   = 4'd4,
    LOP_NAND   = 4'd5,
    LOP_NOR    = 4'd6,
    LOP_XNOR   = 4'd7,
    LOP_ANDN   = 4'd8,
    LOP_POPCNT = 4'd9
  } logic_op_e;

  localparam logic [3:0] LOGIC_OP_LAST = 4'd9;

  function automatic logic is_legal_logic_op(input logic [3:0] op);
    return op <= LOGIC_OP_LAST;
  endfunction

endpackage

// File: rtl/alu_logic_popcnt.sv
// Combinational population count of a WIDTH-bit operand.
module alu_logic_popcnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]             a,
  output logic [$clog2(WIDTH+1)-1:0]   cnt
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(a[i]);
    end
  end

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage valid/ready logic unit: bitwise ops in S1, popcount and flags in S2.
module alu_logic_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [3:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_we,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_par,
  output logic             out_err,
  output logic [3:0]       out_tag
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_val_q,   s1_val_d;
  logic [3:0]       s1_op_q,    s1_op_d;
  logic [3:0]       s1_tag_q,   s1_tag_d;

  logic             s2_valid_q,  s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_we_q,     s2_we_d;
  logic             s2_zero_q,   s2_zero_d;
  logic             s2_neg_q,    s2_neg_d;
  logic             s2_par_q,    s2_par_d;
  logic             s2_err_q,    s2_err_d;
  logic [3:0]       s2_tag_q,    s2_tag_d;

  logic             accept;
  logic             s2_adv;
  logic [WIDTH-1:0] op_val;
  logic [WIDTH-1:0] fin_val;
  logic [CNT_W-1:0] pop_cnt;
  logic             is_test;
  logic             legal;

  alu_logic_popcnt #(.WIDTH(WIDTH)) u_popcnt (
    .a   (s1_val_q),
    .cnt (pop_cnt)
  );

  // S1: accept a beat and evaluate the bitwise op; POPCNT carries a through.
  always_comb begin
    in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    accept   = in_valid && in_ready;
    s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);

    op_val = '0;
    case (logic_op_e'(in_op))
      LOP_AND:    op_val = in_a & in_b;
      LOP_OR:     op_val = in_a | in_b;
      LOP_XOR:    op_val = in_a ^ in_b;
      LOP_NOT:    op_val = ~in_a;
      LOP_TEST:   op_val = in_a & in_b;
      LOP_NAND:   op_val = ~(in_a & in_b);
      LOP_NOR:    op_val = ~(in_a | in_b);
      LOP_XNOR:   op_val = ~(in_a ^ in_b);
      LOP_ANDN:   op_val = in_a & ~in_b;
      LOP_POPCNT: op_val = in_a;
      default:    op_val = '0;
    endcase

    s1_valid_d = s1_valid_q;
    s1_val_d   = s1_val_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_val_d   = op_val;
      s1_op_d    = in_op;
      s1_tag_d   = in_tag;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2: finish the value; TEST keeps a&b for flags but writes no result.
  always_comb begin
    is_test = (s1_op_q == LOP_TEST);
    legal   = is_legal_logic_op(s1_op_q);
    fin_val = (s1_op_q == LOP_POPCNT) ? WIDTH'(pop_cnt) : s1_val_q;

    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_we_d     = s2_we_q;
    s2_zero_d   = s2_zero_q;
    s2_neg_d    = s2_neg_q;
    s2_par_d    = s2_par_q;
    s2_err_d    = s2_err_q;
    s2_tag_d    = s2_tag_q;
    if (s2_adv) begin
      s2_valid_d  = 1'b1;
      s2_result_d = is_test ? '0 : fin_val;
      s2_we_d     = legal && !is_test;
      s2_zero_d   = (fin_val == '0);
      s2_neg_d    = fin_val[WIDTH-1];
      s2_par_d    = ^fin_val;
      s2_err_d    = !legal;
      s2_tag_d    = s1_tag_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      s1_op_q     <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_we_q     <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_neg_q    <= 1'b0;
      s2_par_q    <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_val_q    <= s1_val_d;
      s1_op_q     <= s1_op_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_we_q     <= s2_we_d;
      s2_zero_q   <= s2_zero_d;
      s2_neg_q    <= s2_neg_d;
      s2_par_q    <= s2_par_d;
      s2_err_q    <= s2_err_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_we     = s2_we_q;
  assign out_zero   = s2_zero_q;
  assign out_neg    = s2_neg_q;
  assign out_par    = s2_par_q;
  assign out_err    = s2_err_q;
  assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Scoreboard bench for alu_logic_pipe at WIDTH=16, plus a WIDTH=5 instance.
module tb_alu_logic_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_op, in_tag;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_we, out_zero, out_neg, out_par, out_err;
  logic [3:0]  out_tag;

  logic        p_valid, p_ready;
  logic [4:0]  p_a, p_b;
  logic [3:0]  p_op, p_tag;
  logic        p_ovalid;
  logic        p_oready;
  logic [4:0]  p_res;
  logic        p_we, p_zero, p_neg, p_par, p_err;
  logic [3:0]  p_otag;

  alu_logic_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_we(out_we), .out_zero(out_zero),
    .out_neg(out_neg), .out_par(out_par), .out_err(out_err), .out_tag(out_tag)
  );

  alu_logic_pipe #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(p_valid), .in_ready(p_ready),
    .in_a(p_a), .in_b(p_b), .in_op(p_op), .in_tag(p_tag),
    .out_valid(p_ovalid), .out_ready(p_oready),
    .out_result(p_res), .out_we(p_we), .out_zero(p_zero),
    .out_neg(p_neg), .out_par(p_par), .out_err(p_err), .out_tag(p_otag)
  );

  typedef struct {
    logic [15:0] res;
    logic        we, zero, neg, par, err;
    logic [3:0]  tag;
    logic        chk_res;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] tag);
    exp_t        e;
    logic [15:0] v;
    int          c;
    case (op)
      4'd0: v = a & b;
      4'd1: v = a | b;
      4'd2: v = a ^ b;
      4'd3: v = ~a;
      4'd4: v = a & b;
      4'd5: v = ~(a & b);
      4'd6: v = ~(a | b);
      4'd7: v = ~(a ^ b);
      4'd8: v = a & ~b;
      4'd9: begin
        c = 0;
        for (int i = 0; i < 16; i++) c += int'(a[i]);
        v = 16'(c);
      end
      default: v = 16'h0;
    endcase
    e.res     = (op == 4'd4) ? 16'h0 : v;
    e.we      = (op <= 4'd9) && (op != 4'd4);
    e.err     = (op > 4'd9);
    e.zero    = (v == 16'h0);
    e.neg     = v[15];
    e.par     = ^v;
    e.tag     = tag;
    e.chk_res = (op != 4'd4);
    return e;
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] res, input logic we, input logic zero,
                               input logic neg, input logic par, input logic err);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.e.res = res; v.e.we = we; v.e.zero = zero; v.e.neg = neg;
    v.e.par = par; v.e.err = err; v.e.tag = 4'h0; v.e.chk_res = (op != 4'd4);
    return v;
  endfunction

  // Output monitor: a stalled beat must already match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual_tag=%0h required=none", out_tag);
      end else begin
        e = sb[0];
        if (e.chk_res) chk($sformatf("result_t%0h", e.tag), 64'(out_result), 64'(e.res));
        chk($sformatf("tag_t%0h", e.tag),  64'(out_tag),  64'(e.tag));
        chk($sformatf("we_t%0h", e.tag),   64'(out_we),   64'(e.we));
        chk($sformatf("zero_t%0h", e.tag), 64'(out_zero), 64'(e.zero));
        chk($sformatf("neg_t%0h", e.tag),  64'(out_neg),  64'(e.neg));
        chk($sformatf("par_t%0h", e.tag),  64'(out_par),  64'(e.par));
        chk($sformatf("err_t%0h", e.tag),  64'(out_err),  64'(e.err));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input exp_t e);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = e.tag;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      in_valid = 1'b0;
    end else begin
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic send5(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] exp_res, input string nm);
    int n;
    @(negedge clk);
    p_valid = 1'b1; p_op = op; p_a = a; p_b = b; p_tag = op;
    @(posedge clk);
    #1 p_valid = 1'b0;
    n = 0;
    while (!p_ovalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, 64'(p_ovalid), 64'd1);
    chk({nm, "_result"}, 64'(p_res), 64'(exp_res));
    chk({nm, "_we"}, 64'(p_we), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [3:0]  op;
    logic [15:0] a, b;
    int          stale;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b0;
    p_valid = 1'b0; p_a = '0; p_b = '0; p_op = '0; p_tag = '0; p_oready = 1'b1;

    vecs[0]  = mkv(4'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1, 0, 1, 0, 0);
    vecs[1]  = mkv(4'd4, 16'h00FF, 16'hFF00, 16'h0000, 0, 1, 0, 0, 0);
    vecs[2]  = mkv(4'd5, 16'h00FF, 16'hFF00, 16'hFFFF, 1, 0, 1, 0, 0);
    vecs[3]  = mkv(4'd9, 16'hFFFF, 16'h0000, 16'h0010, 1, 0, 0, 1, 0);
    vecs[4]  = mkv(4'd9, 16'h0000, 16'h1234, 16'h0000, 1, 1, 0, 0, 0);
    vecs[5]  = mkv(4'hC, 16'h1234, 16'h5678, 16'h0000, 0, 1, 0, 0, 1);
    vecs[6]  = mkv(4'd1, 16'h1200, 16'h0034, 16'h1234, 1, 0, 0, 1, 0);
    vecs[7]  = mkv(4'd2, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1, 0, 0, 0, 0);
    vecs[8]  = mkv(4'd3, 16'h0F0F, 16'h1111, 16'hF0F0, 1, 0, 1, 0, 0);
    vecs[9]  = mkv(4'd6, 16'h0000, 16'h0001, 16'hFFFE, 1, 0, 1, 1, 0);
    vecs[10] = mkv(4'd7, 16'h1234, 16'h1234, 16'hFFFF, 1, 0, 1, 0, 0);
    vecs[11] = mkv(4'd8, 16'hFFFF, 16'h00FF, 16'hFF00, 1, 0, 1, 0, 0);
    vecs[12] = mkv(4'd4, 16'h8000, 16'h8001, 16'h0000, 0, 0, 1, 1, 0);
    vecs[13] = mkv(4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 1, 0, 0, 1);

    // Reset state, with out_ready low so in_ready=1 depends on empty stages.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_we", 64'(out_we), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst5_in_ready", 64'(p_ready), 64'd1);
    rst = 1'b0;
    out_ready = 1'b1;

    // Two-cycle latency on an empty pipeline.
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd0; in_a = 16'hF0F0; in_b = 16'hFF00; in_tag = 4'hA;
    e = vecs[0].e; e.tag = 4'hA;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    drain();

    // Table vectors, issued back to back.
    for (int i = 0; i < 14; i++) begin
      e = vecs[i].e;
      e.tag = 4'(i);
      send(vecs[i].op, vecs[i].a, vecs[i].b, e);
    end
    idle();
    drain();

    // Eight-beat stream with a five-cycle downstream stall.
    fork
      begin
        for (int t = 0; t < 8; t++) begin
          op = 4'($urandom_range(0, 9));
          a  = 16'($urandom);
          b  = 16'($urandom);
          send(op, a, b, model(op, a, b, 4'(t)));
        end
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2 out_ready = 1'b1;
        #1 chk("in_ready_follows_out_ready", 64'(in_ready), 64'd1);
      end
    join
    drain();

    // Reset with both stages occupied discards both beats.
    @(posedge clk);
    #2 out_ready = 1'b0;
    e = model(4'd1, 16'h0F00, 16'h00F0, 4'h3);
    send(4'd1, 16'h0F00, 16'h00F0, e);
    e = model(4'd2, 16'h1111, 16'h2222, 4'h4);
    send(4'd2, 16'h1111, 16'h2222, e);
    idle();
    chk("full_in_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_result", 64'(out_result), 64'd0);
    chk("midrst_tag", 64'(out_tag), 64'd0);
    chk("midrst_zero_neg_par", 64'({out_zero, out_neg, out_par, out_we, out_err}), 64'd0);
    sb.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_beats", 64'(stale), 64'd0);

    // Narrow instance.
    send5(4'd7, 5'b10101, 5'b00111, 5'b01101, "w5_xnor");
    send5(4'd9, 5'b11111, 5'b00000, 5'd5, "w5_popcnt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
